dac_2624: RTL and testbench



---
 rtl/dac_2624.sv | 112 +++++++++++
 tb/tb_dac_2624.sv | 162 ++++++++++++++++
 2 files changed

// File: rtl/dac_2624.sv
// dac_2624: SPI write-only driver for an LTC2624-style quad 12-bit DAC.
// Ports:
//   clk         system clock, all logic on the rising edge
//   rst         synchronous active-high reset
//   i_dac_start level start request, only looked at while idle
//   dac_data    12-bit DAC code, captured when a start is accepted
//   spi_miso    DAC readback, unused
//   spi_mosi    serial data, MSB first, changes with falling SCK
//   dac_cs      active-low chip select framing one 32-bit command
//   spi_sck     serial clock, idle low
//   dac_clr     active-low DAC clear, released after reset
module dac_2624 #(
    parameter int         CLK_DIV  = 2,
    parameter logic [3:0] DAC_CMD  = 4'b0011,
    parameter logic [3:0] DAC_ADDR = 4'b1111,
    parameter int         CS_GAP   = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        i_dac_start,
    input  logic [11:0] dac_data,
    input  logic        spi_miso,
    output logic        spi_mosi,
    output logic        dac_cs,
    output logic        spi_sck,
    output logic        dac_clr
);
    typedef enum logic [1:0] {IDLE, SHIFT, HOLD, GAP} state_t;
    localparam logic [15:0] DIV_END = 16'(CLK_DIV - 1);
    localparam logic [15:0] GAP_END = 16'(CS_GAP - 1);
    state_t      state, state_n;
    logic [15:0] cnt, cnt_n;
    logic [5:0]  half, half_n;
    logic [31:0] sh, sh_n, frame;
    logic        mosi_n, cs_n, sck_n;
    logic        unused_miso;
    assign unused_miso = spi_miso;
    assign frame = {8'h00, DAC_CMD, DAC_ADDR, dac_data, 4'h0};
    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= IDLE;
            cnt      <= '0;
            half     <= '0;
            sh       <= '0;
            spi_mosi <= 1'b0;
            dac_cs   <= 1'b1;
            spi_sck  <= 1'b0;
            dac_clr  <= 1'b0;
        end else begin
            state    <= state_n;
            cnt      <= cnt_n;
            half     <= half_n;
            sh       <= sh_n;
            spi_mosi <= mosi_n;
            dac_cs   <= cs_n;
            spi_sck  <= sck_n;
            dac_clr  <= 1'b1;
        end
    end
    // half counts SCK half-periods; the falling edge that ends half 63 closes the 32nd bit
    always_comb begin
        state_n = state;
        cnt_n   = cnt + 16'd1;
        half_n  = half;
        sh_n    = sh;
        mosi_n  = spi_mosi;
        cs_n    = dac_cs;
        sck_n   = spi_sck;
        case (state)
            IDLE: begin
                cnt_n = '0;
                if (i_dac_start) begin
                    state_n = SHIFT;
                    sh_n    = frame;
                    mosi_n  = frame[31];
                    cs_n    = 1'b0;
                    sck_n   = 1'b0;
                    half_n  = '0;
                end
            end
            SHIFT: begin
                if (cnt == DIV_END) begin
                    cnt_n  = '0;
                    half_n = half + 6'd1;
                    sck_n  = ~spi_sck;
                    if (spi_sck) begin
                        if (half == 6'd63) begin
                            state_n = HOLD;
                        end else begin
                            sh_n   = {sh[30:0], 1'b0};
                            mosi_n = sh[30];
                        end
                    end
                end
            end
            HOLD: begin
                if (cnt == DIV_END) begin
                    cnt_n   = '0;
                    state_n = GAP;
                    cs_n    = 1'b1;
                    mosi_n  = 1'b0;
                end
            end
            GAP: begin
                if (cnt == GAP_END) begin
                    cnt_n   = '0;
                    state_n = IDLE;
                end
            end
        endcase
    end
endmodule

// File: tb/tb_dac_2624.sv
// tb_dac_2624: directed + randomized checks of dac_2624 frames against a frame-level model.
module tb_dac_2624;
    logic clk = 1'b0;
    always #5 clk = ~clk;
    logic        rst, start, start1, miso;
    logic [11:0] data, data1;
    logic        mosi, cs, sck, clr, mosi1, cs1, sck1, clr1;
    int          vectors = 0, errors = 0, cyc = 0, stray = 0;
    bit          ps = 1'b0, ps1 = 1'b0;

    dac_2624 dut (.clk(clk), .rst(rst), .i_dac_start(start), .dac_data(data), .spi_miso(miso),
                  .spi_mosi(mosi), .dac_cs(cs), .spi_sck(sck), .dac_clr(clr));
    dac_2624 #(.CLK_DIV(1)) dut1 (.clk(clk), .rst(rst), .i_dac_start(start1), .dac_data(data1),
                  .spi_miso(miso), .spi_mosi(mosi1), .dac_cs(cs1), .spi_sck(sck1), .dac_clr(clr1));

    always @(posedge clk) cyc++;
    always @(negedge clk) begin
        miso = 1'($urandom_range(1));
        if (cs === 1'b1 && sck === 1'b1 && !ps) stray++;
        if (cs1 === 1'b1 && sck1 === 1'b1 && !ps1) stray++;
        ps  = sck;
        ps1 = sck1;
    end

    function automatic logic [31:0] model(input logic [11:0] d);
        return (32'h3 << 20) | (32'hF << 16) | (32'(d) << 4);
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // collects one CS-low frame starting at the current negedge
    task automatic get_frame(input bit fast, output logic [31:0] word, output int low,
                             output int edges, output int smin, output int smax, output int t0);
        int n = 0;
        int last = 0;
        bit p = 1'b0;
        word = '0; low = 0; edges = 0; smin = 1000; smax = 0;
        while ((fast ? cs1 : cs) !== 1'b0 && n < 400) begin
            @(negedge clk);
            n++;
        end
        check("cs_fall", 32'(fast ? cs1 : cs), 32'd0);
        t0 = cyc;
        while ((fast ? cs1 : cs) === 1'b0 && low < 300) begin
            low++;
            if ((fast ? sck1 : sck) === 1'b1 && !p) begin
                word = {word[30:0], fast ? mosi1 : mosi};
                if (edges > 0) begin
                    if (low - last < smin) smin = low - last;
                    if (low - last > smax) smax = low - last;
                end
                last = low;
                edges++;
            end
            p = (fast ? sck1 : sck) === 1'b1;
            @(negedge clk);
        end
    endtask

    initial begin
        logic [31:0] w;
        logic [11:0] cur;
        int low, edges, smin, smax, t0, prev, prev_low, rises;
        bit p;
        rst = 1'b1; start = 1'b0; start1 = 1'b0; data = '0; data1 = '0;
        repeat (5) @(negedge clk);
        check("rst_cs", 32'(cs), 32'd1);
        check("rst_sck", 32'(sck), 32'd0);
        check("rst_mosi", 32'(mosi), 32'd0);
        check("rst_clr", 32'(clr), 32'd0);
        rst = 1'b0;
        @(negedge clk);
        check("clr_release", 32'(clr), 32'd1);
        repeat (20) @(negedge clk);
        check("idle_cs", 32'(cs), 32'd1);
        check("idle_mosi", 32'(mosi), 32'd0);

        data = 12'd234;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        check("start_latency", 32'(cs), 32'd0);
        get_frame(1'b0, w, low, edges, smin, smax, t0);
        check("single_word", w, model(12'd234));
        check("single_low", 32'(low), 32'd130);
        check("single_edges", 32'(edges), 32'd32);
        check("single_smin", 32'(smin), 32'd4);
        check("single_smax", 32'(smax), 32'd4);
        repeat (10) @(negedge clk);

        cur = 12'd234;
        start = 1'b1;
        prev = 0;
        prev_low = 0;
        for (int f = 0; f < 5; f++) begin
            fork
                get_frame(1'b0, w, low, edges, smin, smax, t0);
                begin
                    repeat (20 + $urandom_range(60)) @(negedge clk);
                    data = (f == 0) ? 12'hFFF : 12'($urandom);
                end
            join
            check("held_word", w, model(cur));
            check("held_low", 32'(low), 32'd130);
            check("held_edges", 32'(edges), 32'd32);
            if (f > 0) begin
                check("held_period", 32'(t0 - prev), 32'd135);
                check("held_gap", 32'(t0 - prev - prev_low >= 4), 32'd1);
            end
            prev = t0;
            prev_low = low;
            cur = (f == 0) ? 12'hFFF : 12'($urandom);
            data = cur;
        end

        rises = 0;
        p = 1'b0;
        for (int n = 0; n < 400 && rises < 10; n++) begin
            @(negedge clk);
            if (cs === 1'b0 && sck === 1'b1 && !p) rises++;
            p = sck === 1'b1;
        end
        check("abort_reached", 32'(rises), 32'd10);
        rst = 1'b1;
        @(negedge clk);
        check("abort_cs", 32'(cs), 32'd1);
        check("abort_sck", 32'(sck), 32'd0);
        check("abort_mosi", 32'(mosi), 32'd0);
        check("abort_clr", 32'(clr), 32'd0);
        repeat (2) @(negedge clk);
        check("abort_hold_sck", 32'(sck), 32'd0);
        rst = 1'b0;
        get_frame(1'b0, w, low, edges, smin, smax, t0);
        check("restart_word", w, model(cur));
        check("restart_low", 32'(low), 32'd130);
        check("restart_edges", 32'(edges), 32'd32);
        start = 1'b0;

        data1 = 12'h800;
        @(negedge clk);
        start1 = 1'b1;
        @(negedge clk);
        start1 = 1'b0;
        get_frame(1'b1, w, low, edges, smin, smax, t0);
        check("fast_word", w, model(12'h800));
        check("fast_low", 32'(low), 32'd65);
        check("fast_edges", 32'(edges), 32'd32);
        check("fast_smin", 32'(smin), 32'd2);
        check("fast_smax", 32'(smax), 32'd2);
        check("fast_clr", 32'(clr1), 32'd1);
        repeat (10) @(negedge clk);
        check("stray_sck", 32'(stray), 32'd0);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end
endmodule
